// File: rtl/mem_access_ctrl.sv
// Command-driven initiator for the 8x4 scratch memory: set-up/strobe write sequencing, read data
// returned on a valid/ready response channel. Define MEM_ACCESS_WR_ACK_EN to add a write acknowledge.
module mem_access_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Handshakes: cmd transfers on a rising edge with cmd_valid & cmd_ready; a response word
    // transfers on a rising edge with rsp_valid & rsp_ready and is held unchanged until then.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        RD_ADDR   = 3'd3,
        RD_RESP   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] next_idx;

    assign next_idx = idx_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            start_q     <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            start_q     <= start_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_d     = start_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_d    = mem_wr_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                // Accept uses the registered ready, so nothing is taken on the first edge out of reset.
                if (cmd_valid && cmd_ready_q) begin
                    start_d     = cmd_addr;
                    len_d       = cmd_len;
                    wdata_d     = cmd_wdata;
                    idx_d       = '0;
                    cmd_ready_d = 1'b0;
                    mem_addr_d  = cmd_addr;
                    mem_wr_d    = 1'b0;
                    if (cmd_wr) begin
                        mem_wdata_d = cmd_wdata;
                        state_d     = WR_SETUP;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_SETUP: begin
                mem_wr_d = 1'b1;
                state_d  = WR_STROBE;
            end
            WR_STROBE: begin
                mem_wr_d = 1'b0;
                if (idx_q < len_q) begin
                    idx_d       = next_idx;
                    mem_addr_d  = start_q + next_idx;
                    mem_wdata_d = wdata_q + DATA_W'(next_idx);
                    state_d     = WR_SETUP;
                end else begin
`ifdef MEM_ACCESS_WR_ACK_EN
                    // Write acknowledge reuses the read response state; idx == len so it exits to IDLE.
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = RD_RESP;
`else
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
`endif
                end
            end
            RD_ADDR: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (idx_q == len_q);
                state_d     = RD_RESP;
            end
            RD_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (idx_q < len_q) begin
                        idx_d      = next_idx;
                        mem_addr_d = start_q + next_idx;
                        state_d    = RD_ADDR;
                    end else begin
                        cmd_ready_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised self-checking bench for mem_access_ctrl with an 8x4 memory model and a word-level reference.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_ACCESS_WR_ACK_EN
    localparam int ACK_CYC = 1;
`else
    localparam int ACK_CYC = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    // Memory under control, and the reference image of what it should hold.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              load_en;
    logic [DATA_W-1:0] exp_q[$];

    // Observations collected by the drivers.
    logic [ADDR_W-1:0] obs_waddr[$];
    logic [DATA_W-1:0] obs_wdata[$];
    logic [DATA_W-1:0] obs_rdata[$];
    logic              obs_rlast[$];
    int                obs_setup_err, obs_busy_cyc, obs_ack_cnt, obs_rej_err;
    int                obs_stable_err, obs_first_valid, obs_rd_cyc, obs_wr_in_rd;
    logic              obs_ack_last;
    logic [DATA_W-1:0] obs_ack_data;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // ---------------- clock and memory model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    // ---------------- reference model ----------------
    function automatic void ref_write(input int a, input int len, input int d);
        for (int k = 0; k <= len; k++) ref_mem[(a + k) % DEPTH] = DATA_W'((d + k) % (1 << DATA_W));
    endfunction

    function automatic void ref_expect_read(input int a, input int len);
        exp_q.delete();
        for (int k = 0; k <= len; k++) exp_q.push_back(ref_mem[(a + k) % DEPTH]);
    endfunction

    // ---------------- drivers (entered and left on a negedge) ----------------
    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len,
                            input logic [DATA_W-1:0] d);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_wdata = d;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
            cmd_valid = 1'b0;
        end else begin
            @(negedge clk);
            cmd_valid = 1'b0;
            // Scramble fields: the controller must only use what it saw on the accept edge.
            cmd_wr    = 1'($urandom);
            cmd_addr  = ADDR_W'($urandom);
            cmd_len   = ADDR_W'($urandom);
            cmd_wdata = DATA_W'($urandom);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len,
                            input logic [DATA_W-1:0] d, input bit inject);
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        logic              pw;
        int                cyc = 0;
        obs_waddr.delete();
        obs_wdata.delete();
        obs_setup_err = 0; obs_busy_cyc = 0; obs_ack_cnt = 0; obs_rej_err = 0;
        obs_ack_last = 1'b0; obs_ack_data = '0;
        send_cmd(1'b1, a, len, d);
        pa = '0; pd = '0; pw = 1'b1;
        while (busy === 1'b1 && cyc < 100) begin
            if (inject) begin
                if (cyc >= 1 && cyc <= 4) begin
                    cmd_valid = 1'b1;
                    cmd_wr    = 1'b1;
                    cmd_addr  = a + ADDR_W'(4);
                    cmd_len   = '0;
                    cmd_wdata = ~d;
                    if (cmd_ready !== 1'b0) obs_rej_err++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (mem_wr === 1'b1) begin
                obs_waddr.push_back(mem_addr);
                obs_wdata.push_back(mem_wdata);
                if (pw !== 1'b0 || mem_addr !== pa || mem_wdata !== pd) obs_setup_err++;
            end
            if (rsp_valid === 1'b1) begin
                obs_ack_cnt++;
                obs_ack_last = rsp_last;
                obs_ack_data = rsp_data;
                rsp_ready    = 1'b1;
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
            pa = mem_addr; pd = mem_wdata; pw = mem_wr;
            obs_busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (cyc >= 100) begin
            n_err++;
            $display("FAIL write_timeout: busy still %b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len,
                           input int stall_word, input int stall_cycles, input bit rand_bp);
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        logic              pl, pv, pr, rdy;
        int                cyc = 0;
        int                got = 0;
        int                stall_left = stall_cycles;
        obs_rdata.delete();
        obs_rlast.delete();
        obs_stable_err = 0; obs_first_valid = -1; obs_wr_in_rd = 0;
        send_cmd(1'b0, a, len, '0);
        pa = '0; pd = '0; pl = 1'b0; pv = 1'b0; pr = 1'b0;
        while (got < int'(len) + 1 && cyc < 300) begin
            if (mem_wr === 1'b1) obs_wr_in_rd++;
            if (rsp_valid === 1'b1) begin
                if (obs_first_valid < 0) obs_first_valid = cyc;
                if (pv && !pr && (rsp_data !== pd || rsp_last !== pl || mem_addr !== pa)) obs_stable_err++;
                if (got == stall_word && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (rand_bp) begin
                    rdy = ($urandom_range(0, 2) != 0);
                end else begin
                    rdy = 1'b1;
                end
                if (rdy) begin
                    obs_rdata.push_back(rsp_data);
                    obs_rlast.push_back(rsp_last);
                    got++;
                end
                rsp_ready = rdy;
            end else begin
                rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pl = rsp_last; pa = mem_addr;
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b0;
        while (busy === 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        obs_rd_cyc = cyc;
        n_cmp++;
        if (cyc >= 300) begin
            n_err++;
            $display("FAIL read_timeout: got %0d of %0d words, busy=%b", got, int'(len) + 1, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; load_en = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd3; cmd_len = 3'd2; cmd_wdata = 4'h5;
        rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'($urandom);
        repeat (3) @(negedge clk);
        load_en = 1'b0;
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_last, mem_addr, mem_wdata, mem_wr, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h rl=%b ma=%h mw=%h wr=%b busy=%b, required all 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_last, mem_addr, mem_wdata, mem_wr, busy);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_ready: cmd_ready=%b before first edge, required 0", cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_edge: cmd_ready=%b busy=%b, required 1 and 0", cmd_ready, busy);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || mem_wr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_accept: busy=%b mem_wr=%b, required 0 and 0", busy, mem_wr);
        end
    endtask

    task automatic test_single_write_read();
        do_write(3'd5, 3'd0, 4'hA, 1'b0);
        n_cmp++;
        if (obs_waddr.size() != 1 || obs_waddr[0] !== 3'd5 || obs_wdata[0] !== 4'hA) begin
            n_err++;
            $display("FAIL single_write_strobe: %0d strobes first addr=%h data=%h, required 1 strobe 5/a",
                     obs_waddr.size(), obs_waddr.size() ? obs_waddr[0] : 3'd0, obs_wdata.size() ? obs_wdata[0] : 4'd0);
        end
        n_cmp++;
        if (obs_setup_err != 0 || obs_busy_cyc != 2 + ACK_CYC) begin
            n_err++;
            $display("FAIL single_write_timing: setup_err=%0d busy_cyc=%0d, required 0 and %0d",
                     obs_setup_err, obs_busy_cyc, 2 + ACK_CYC);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_write_ready: cmd_ready=%b after write, required 1", cmd_ready);
        end
`ifdef MEM_ACCESS_WR_ACK_EN
        n_cmp++;
        if (obs_ack_cnt != 1 || obs_ack_last !== 1'b1 || obs_ack_data !== '0) begin
            n_err++;
            $display("FAIL write_ack: count=%0d last=%b data=%h, required 1/1/0", obs_ack_cnt, obs_ack_last, obs_ack_data);
        end
`else
        n_cmp++;
        if (obs_ack_cnt != 0) begin
            n_err++;
            $display("FAIL write_no_rsp: %0d responses on write, required 0", obs_ack_cnt);
        end
`endif
        ref_write(5, 0, 4'hA);
        do_read(3'd5, 3'd0, -1, 0, 1'b0);
        n_cmp++;
        if (obs_rdata.size() != 1 || obs_rdata[0] !== 4'hA || obs_rlast[0] !== 1'b1) begin
            n_err++;
            $display("FAIL single_read: %0d words data=%h last=%b, required 1 word a/1", obs_rdata.size(),
                     obs_rdata.size() ? obs_rdata[0] : 4'd0, obs_rlast.size() ? obs_rlast[0] : 1'b0);
        end
        n_cmp++;
        if (obs_first_valid != 1 || obs_wr_in_rd != 0) begin
            n_err++;
            $display("FAIL single_read_latency: rsp_valid at cycle %0d wr_in_rd=%0d, required 1 and 0",
                     obs_first_valid, obs_wr_in_rd);
        end
    endtask

    task automatic test_wrap_burst();
        do_write(3'd6, 3'd3, 4'hE, 1'b0);
        n_cmp++;
        if (obs_waddr.size() != 4 || obs_setup_err != 0 || obs_busy_cyc != 8 + ACK_CYC) begin
            n_err++;
            $display("FAIL wrap_write_shape: strobes=%0d setup_err=%0d busy_cyc=%0d, required 4/0/%0d",
                     obs_waddr.size(), obs_setup_err, obs_busy_cyc, 8 + ACK_CYC);
        end
        for (int k = 0; k < obs_waddr.size() && k < 4; k++) begin
            n_cmp++;
            if (obs_waddr[k] !== ADDR_W'(6 + k) || obs_wdata[k] !== DATA_W'(14 + k)) begin
                n_err++;
                $display("FAIL wrap_write_word%0d: addr=%h data=%h, required %h/%h", k, obs_waddr[k], obs_wdata[k],
                         ADDR_W'(6 + k), DATA_W'(14 + k));
            end
        end
        ref_write(6, 3, 14);
        ref_expect_read(6, 3);
        do_read(3'd6, 3'd3, -1, 0, 1'b0);
        n_cmp++;
        if (obs_rdata.size() != 4 || obs_rd_cyc != 8) begin
            n_err++;
            $display("FAIL wrap_read_shape: words=%0d cycles=%0d, required 4 and 8", obs_rdata.size(), obs_rd_cyc);
        end
        for (int k = 0; k < obs_rdata.size() && k < 4; k++) begin
            n_cmp++;
            if (obs_rdata[k] !== exp_q[k] || obs_rlast[k] !== (k == 3)) begin
                n_err++;
                $display("FAIL wrap_read_word%0d: data=%h last=%b, required %h/%b", k, obs_rdata[k], obs_rlast[k],
                         exp_q[k], (k == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        ref_expect_read(0, 2);
        do_read(3'd0, 3'd2, 1, 5, 1'b0);
        n_cmp++;
        if (obs_stable_err != 0 || obs_rdata.size() != 3 || obs_rd_cyc != 11) begin
            n_err++;
            $display("FAIL backpressure_hold: stable_err=%0d words=%0d cycles=%0d, required 0/3/11",
                     obs_stable_err, obs_rdata.size(), obs_rd_cyc);
        end
        for (int k = 0; k < obs_rdata.size() && k < 3; k++) begin
            n_cmp++;
            if (obs_rdata[k] !== exp_q[k] || obs_rlast[k] !== (k == 2)) begin
                n_err++;
                $display("FAIL backpressure_word%0d: data=%h last=%b, required %h/%b", k, obs_rdata[k], obs_rlast[k],
                         exp_q[k], (k == 2));
            end
        end
    endtask

    task automatic test_busy_reject();
        logic [DATA_W-1:0] seed;
        seed = DATA_W'($urandom);
        do_write(3'd2, 3'd3, seed, 1'b1);
        n_cmp++;
        if (obs_rej_err != 0 || obs_waddr.size() != 4) begin
            n_err++;
            $display("FAIL busy_reject: ready_while_busy=%0d strobes=%0d, required 0 and 4", obs_rej_err, obs_waddr.size());
        end
        ref_write(2, 3, int'(seed));
        ref_expect_read(0, 7);
        do_read(3'd0, 3'd7, -1, 0, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++;
            if (k >= obs_rdata.size() || obs_rdata[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL busy_reject_mem%0d: data=%h, required %h", k, k < obs_rdata.size() ? obs_rdata[k] : 4'hx, exp_q[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        send_cmd(1'b1, 3'd0, 3'd7, 4'h3);
        while (!(mem_wr === 1'b1 && mem_addr === 3'd2) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || cyc >= 40) begin
            n_err++;
            $display("FAIL async_reset_strobe: mem_wr=%b busy=%b wait=%0d, required 0/0/<40", mem_wr, busy, cyc);
        end
        ref_write(0, 1, 3);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ref_expect_read(0, 7);
        do_read(3'd0, 3'd7, -1, 0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++;
            if (k >= obs_rdata.size() || obs_rdata[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL async_reset_mem%0d: data=%h, required %h", k, k < obs_rdata.size() ? obs_rdata[k] : 4'hx, exp_q[k]);
            end
        end
        // A pending read response must be dropped by reset.
        send_cmd(1'b0, 3'd4, 3'd1, '0);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || busy !== 1'b0 || cyc >= 10) begin
            n_err++;
            $display("FAIL async_reset_rsp: rsp_valid=%b rsp_last=%b busy=%b wait=%0d, required 0/0/0/<10",
                     rsp_valid, rsp_last, busy, cyc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic              wr;
        logic [ADDR_W-1:0] a, len;
        logic [DATA_W-1:0] d;
        for (int n = 0; n < 24; n++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = ADDR_W'($urandom);
            len = ADDR_W'($urandom);
            d   = DATA_W'($urandom);
            if (wr) begin
                do_write(a, len, d, 1'b0);
                n_cmp++;
                if (obs_waddr.size() != int'(len) + 1 || obs_setup_err != 0 || obs_ack_cnt != ACK_CYC) begin
                    n_err++;
                    $display("FAIL rand_write%0d: strobes=%0d setup_err=%0d acks=%0d, required %0d/0/%0d", n,
                             obs_waddr.size(), obs_setup_err, obs_ack_cnt, int'(len) + 1, ACK_CYC);
                end
                for (int k = 0; k < obs_waddr.size() && k <= int'(len); k++) begin
                    n_cmp++;
                    if (obs_waddr[k] !== ADDR_W'(int'(a) + k) || obs_wdata[k] !== DATA_W'(int'(d) + k)) begin
                        n_err++;
                        $display("FAIL rand_write%0d_word%0d: addr=%h data=%h, required %h/%h", n, k, obs_waddr[k],
                                 obs_wdata[k], ADDR_W'(int'(a) + k), DATA_W'(int'(d) + k));
                    end
                end
                ref_write(int'(a), int'(len), int'(d));
            end else begin
                ref_expect_read(int'(a), int'(len));
                do_read(a, len, -1, 0, 1'b1);
                n_cmp++;
                if (obs_rdata.size() != int'(len) + 1 || obs_stable_err != 0) begin
                    n_err++;
                    $display("FAIL rand_read%0d: words=%0d stable_err=%0d, required %0d and 0", n, obs_rdata.size(),
                             obs_stable_err, int'(len) + 1);
                end
                for (int k = 0; k < obs_rdata.size() && k <= int'(len); k++) begin
                    n_cmp++;
                    if (obs_rdata[k] !== exp_q[k] || obs_rlast[k] !== (k == int'(len))) begin
                        n_err++;
                        $display("FAIL rand_read%0d_word%0d: data=%h last=%b, required %h/%b", n, k, obs_rdata[k],
                                 obs_rlast[k], exp_q[k], (k == int'(len)));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_wrap_burst();
        test_backpressure();
        test_busy_reject();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
